// File: rtl/ddr_pkg.sv
// Shared DDR refresh definitions: controller state encoding and default JEDEC-style timings.
package ddr_pkg;

    typedef enum logic [2:0] {
        WAIT_INI = 3'd0,
        RUN      = 3'd1,
        DRAIN    = 3'd2,
        PREA     = 3'd3,
        WAIT_RP  = 3'd4,
        REF      = 3'd5,
        WAIT_RFC = 3'd6
    } refresh_state_e;

    localparam int DEF_TREFI      = 6240;
    localparam int DEF_TRFC       = 280;
    localparam int DEF_TRP        = 15;
    localparam int DEF_ALMOST_WIN = 64;
    localparam int DEF_MAX_DEBT   = 8;

    // Width of a down-counter that must hold the larger of two reload values minus one.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/refresh_ctrl_if.sv
// Command-arbiter side signals of the refresh controller.
interface refresh_ctrl_if;
    logic       ini_done;
    logic       rw_idle;
    logic       bank_open;
    logic       refresh_almost;
    logic       busy;
    logic       prea_rdy;
    logic       refresh_rdy;
    logic       refresh_done;
    logic [3:0] ref_debt;
    logic       ref_err;

    modport master (
        input  ini_done, rw_idle, bank_open,
        output refresh_almost, busy, prea_rdy, refresh_rdy, refresh_done, ref_debt, ref_err
    );

    modport slave (
        output ini_done, rw_idle, bank_open,
        input  refresh_almost, busy, prea_rdy, refresh_rdy, refresh_done, ref_debt, ref_err
    );
endinterface

// File: rtl/refresh_ctrl.sv
// DRAM auto-refresh scheduler: tracks postponed refreshes and sequences PREA/REF on the bus.
//
// state    | meaning
// WAIT_INI | DRAM not initialised, interval counter held at 0
// RUN      | arbiter owns the bus, refreshes accumulate as debt
// DRAIN    | bus claimed, waiting for in-flight traffic to finish
// PREA     | precharge-all strobe
// WAIT_RP  | tRP recovery after precharge
// REF      | refresh strobe
// WAIT_RFC | tRFC recovery after refresh
module refresh_ctrl
    import ddr_pkg::*;
#(
    parameter int tREFI      = DEF_TREFI,
    parameter int tRFC       = DEF_TRFC,
    parameter int tRP        = DEF_TRP,
    parameter int ALMOST_WIN = DEF_ALMOST_WIN,
    parameter int MAX_DEBT   = DEF_MAX_DEBT
) (
    input  logic           clock,
    input  logic           reset,
    refresh_ctrl_if.master bus
);

    localparam int CNT_W = $clog2(tREFI + 1);
    localparam int TIM_W = timer_width(tRP, tRFC);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(tREFI - 1);
    localparam logic [CNT_W-1:0] ALMOST_TH = CNT_W'(tREFI - ALMOST_WIN);
    localparam logic [TIM_W-1:0] RP_LOAD   = TIM_W'(tRP - 1);
    localparam logic [TIM_W-1:0] RFC_LOAD  = TIM_W'(tRFC - 1);
    localparam logic [3:0]       DEBT_MAX  = 4'(MAX_DEBT);

    refresh_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TIM_W-1:0] tim_q, tim_d;
    logic [3:0]       debt_q, debt_d;
    logic             err_q, err_d;
    logic             almost_q, busy_q, prea_q, ref_q, done_q;
    logic             wrap, ref_issue;

    always_comb begin
        wrap      = (state_q != WAIT_INI) && (cnt_q == CNT_LAST);
        ref_issue = (state_q == REF);

        if (state_q == WAIT_INI || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // A wrap and a REF in the same cycle cancel out, even at saturation.
        debt_d = debt_q;
        err_d  = err_q;
        if (wrap && !ref_issue) begin
            if (debt_q == DEBT_MAX) begin
                err_d = 1'b1;
            end else begin
                debt_d = debt_q + 4'd1;
            end
        end else if (!wrap && ref_issue && debt_q != 4'd0) begin
            debt_d = debt_q - 4'd1;
        end

        state_d = state_q;
        tim_d   = tim_q;
        case (state_q)
            WAIT_INI: begin
                if (bus.ini_done) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if ((debt_q != 4'd0 && bus.rw_idle) || debt_q == DEBT_MAX) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.rw_idle) begin
                    state_d = bus.bank_open ? PREA : REF;
                end
            end
            PREA: begin
                state_d = WAIT_RP;
                tim_d   = RP_LOAD;
            end
            WAIT_RP: begin
                if (tim_q == '0) begin
                    state_d = REF;
                end else begin
                    tim_d = tim_q - TIM_W'(1);
                end
            end
            REF: begin
                state_d = WAIT_RFC;
                tim_d   = RFC_LOAD;
            end
            WAIT_RFC: begin
                if (tim_q == '0) begin
                    state_d = RUN;
                end else begin
                    tim_d = tim_q - TIM_W'(1);
                end
            end
            default: begin
                state_d = WAIT_INI;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with state_q.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= WAIT_INI;
            cnt_q    <= '0;
            tim_q    <= '0;
            debt_q   <= 4'd0;
            err_q    <= 1'b0;
            almost_q <= 1'b0;
            busy_q   <= 1'b0;
            prea_q   <= 1'b0;
            ref_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tim_q    <= tim_d;
            debt_q   <= debt_d;
            err_q    <= err_d;
            almost_q <= (debt_d != 4'd0) || (cnt_d >= ALMOST_TH);
            busy_q   <= !(state_d inside {WAIT_INI, RUN});
            prea_q   <= (state_d == PREA);
            ref_q    <= (state_d == REF);
            done_q   <= (state_d == WAIT_RFC) && (tim_d == '0);
        end
    end

    assign bus.refresh_almost = almost_q;
    assign bus.busy           = busy_q;
    assign bus.prea_rdy       = prea_q;
    assign bus.refresh_rdy    = ref_q;
    assign bus.refresh_done   = done_q;
    assign bus.ref_debt       = debt_q;
    assign bus.ref_err        = err_q;

endmodule

// File: tb/tb_refresh_ctrl.sv
// Bench for refresh_ctrl: timeline-script reference model plus directed timing pins and random traffic.
module tb_refresh_ctrl;

    localparam int P_REFI = 100;
    localparam int P_RFC  = 20;
    localparam int P_RP   = 5;
    localparam int P_WIN  = 10;
    localparam int P_MAX  = 8;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    refresh_ctrl_if bus ();

    refresh_ctrl #(
        .tREFI(P_REFI), .tRFC(P_RFC), .tRP(P_RP), .ALMOST_WIN(P_WIN), .MAX_DEBT(P_MAX)
    ) dut (
        .clock(clock),
        .reset(rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 pre-init, 1 arbiter owns bus, 2 waiting for idle bus,
    // 3 playing a fixed command timeline (codes: 0 busy, 1 PREA, 2 REF, 3 done).
    int  m_mode = 0;
    int  m_cnt  = 0;
    int  m_debt = 0;
    bit  m_err  = 0;
    int  m_cur  = -1;
    int  m_script[$];
    bit  model_ok = 0;
    bit  m_wrap;
    int  m_old_debt;

    always @(posedge clock) begin
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_debt = 0; m_err = 0; m_cur = -1;
            m_script.delete();
            model_ok = 1;
        end else begin
            m_wrap     = (m_mode != 0) && (m_cnt == P_REFI - 1);
            m_old_debt = m_debt;
            if (m_wrap && m_cur != 2) begin
                if (m_debt == P_MAX) m_err = 1;
                else m_debt++;
            end else if (!m_wrap && m_cur == 2 && m_debt > 0) begin
                m_debt--;
            end
            m_cnt = (m_mode == 0) ? 0 : (m_cnt + 1) % P_REFI;
            case (m_mode)
                0: if (bus.ini_done) m_mode = 1;
                1: if ((m_old_debt > 0 && bus.rw_idle) || m_old_debt == P_MAX) m_mode = 2;
                2: if (bus.rw_idle) begin
                    if (bus.bank_open) begin
                        m_script.push_back(1);
                        repeat (P_RP) m_script.push_back(0);
                    end
                    m_script.push_back(2);
                    repeat (P_RFC - 1) m_script.push_back(0);
                    m_script.push_back(3);
                    m_mode = 3;
                end
                default: ;
            endcase
            if (m_mode == 3) begin
                if (m_script.size() == 0) begin
                    m_mode = 1;
                    m_cur  = -1;
                end else begin
                    m_cur = m_script.pop_front();
                end
            end
        end
    end

    always @(negedge clock) begin
        if (model_ok) begin
            chk("refresh_almost", int'(bus.refresh_almost),
                int'((m_debt > 0) || (m_cnt >= P_REFI - P_WIN)));
            chk("busy",         int'(bus.busy),         int'(m_mode >= 2));
            chk("prea_rdy",     int'(bus.prea_rdy),     int'(m_cur == 1));
            chk("refresh_rdy",  int'(bus.refresh_rdy),  int'(m_cur == 2));
            chk("refresh_done", int'(bus.refresh_done), int'(m_cur == 3));
            chk("ref_debt",     int'(bus.ref_debt),     m_debt);
            chk("ref_err",      int'(bus.ref_err),      int'(m_err));
            chk("strobe_excl",  int'($onehot0({bus.prea_rdy, bus.refresh_rdy, bus.refresh_done})), 1);
        end
    end

    function automatic bit pick(input int w);
        case (w)
            0: return bus.refresh_almost;
            1: return bus.prea_rdy;
            2: return bus.refresh_rdy;
            3: return bus.refresh_done;
            default: return bus.busy;
        endcase
    endfunction

    task automatic wait_sig(input int w, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clock);
            if (pick(w)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        rst = 1'b1;
        bus.ini_done = 1'b0;
        @(negedge clock);
        chk("rst_outputs",
            int'({bus.refresh_almost, bus.busy, bus.prea_rdy, bus.refresh_rdy,
                  bus.refresh_done, bus.ref_debt, bus.ref_err}), 0);
        rst = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int n;
        int pct;
        int dones;
        bus.ini_done  = 1'b0;
        bus.rw_idle   = 1'b0;
        bus.bank_open = 1'b0;

        // Idle bus, no open bank
        do_reset();
        bus.ini_done = 1'b1; bus.rw_idle = 1'b1; bus.bank_open = 1'b0;
        wait_sig(0, 200, n);  chk("almost_rise_cycle", n, 91);
        wait_sig(2, 50, n);   chk("ref_after_almost", n, 12);
        wait_sig(3, 50, n);   chk("done_after_ref", n, 20);

        // Open bank: PREA first, REF six cycles later
        do_reset();
        bus.ini_done = 1'b1; bus.rw_idle = 1'b1; bus.bank_open = 1'b1;
        wait_sig(1, 200, n);  chk("prea_cycle", n, 103);
        wait_sig(2, 20, n);   chk("prea_to_ref", n, 6);
        wait_sig(3, 50, n);   chk("done_after_ref_b", n, 20);
        chk("debt_after_ref", int'(bus.ref_debt), 0);

        // Busy traffic: debt saturates, urgent drain, no overflow
        do_reset();
        bus.ini_done = 1'b1; bus.rw_idle = 1'b0; bus.bank_open = 1'b0;
        repeat (801) @(negedge clock);
        chk("debt_at_8", int'(bus.ref_debt), 8);
        chk("busy_before_urgent", int'(bus.busy), 0);
        @(negedge clock);
        chk("busy_urgent", int'(bus.busy), 1);
        repeat (48) @(negedge clock);
        chk("debt_held_8", int'(bus.ref_debt), 8);
        bus.rw_idle = 1'b1;
        wait_sig(2, 2, n);    chk("ref_after_idle", n, 1);
        repeat (300) @(negedge clock);
        chk("no_err_after_drain", int'(bus.ref_err), 0);

        // Nine wraps without a refresh: sticky overflow
        do_reset();
        bus.ini_done = 1'b1; bus.rw_idle = 1'b0; bus.bank_open = 1'b1;
        repeat (900) @(negedge clock);
        chk("err_before_9th", int'(bus.ref_err), 0);
        @(negedge clock);
        chk("err_after_9th", int'(bus.ref_err), 1);
        chk("debt_sat", int'(bus.ref_debt), 8);
        bus.rw_idle = 1'b1;
        repeat (400) @(negedge clock);
        chk("err_sticky", int'(bus.ref_err), 1);

        // Reset in the middle of tRFC
        do_reset();
        bus.ini_done = 1'b1; bus.rw_idle = 1'b1; bus.bank_open = 1'b0;
        wait_sig(2, 200, n);  chk("ref_before_abort", n, 103);
        repeat (5) @(negedge clock);
        rst = 1'b1; bus.ini_done = 1'b0;
        @(negedge clock);
        chk("abort_outputs",
            int'({bus.refresh_almost, bus.busy, bus.prea_rdy, bus.refresh_rdy,
                  bus.refresh_done, bus.ref_debt, bus.ref_err}), 0);
        rst = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clock);
            dones += int'(bus.refresh_done) + int'(bus.refresh_rdy) + int'(bus.busy);
        end
        chk("abort_quiet", dones, 0);

        // Wrap lands on the REF cycle with debt 1
        do_reset();
        bus.ini_done = 1'b1; bus.rw_idle = 1'b0; bus.bank_open = 1'b0;
        repeat (198) @(negedge clock);
        chk("debt_pre_coincide", int'(bus.ref_debt), 1);
        bus.rw_idle = 1'b1;
        wait_sig(2, 5, n);    chk("ref_on_wrap_cycle", n, 2);
        @(negedge clock);
        chk("debt_coincide", int'(bus.ref_debt), 1);

        // Random traffic against the model
        for (int seg = 0; seg < 8; seg++) begin
            do_reset();
            bus.rw_idle = 1'b0;
            repeat ($urandom_range(0, 20)) @(negedge clock);
            bus.ini_done = 1'b1;
            case (seg % 4)
                0: pct = 0;
                1: pct = 20;
                2: pct = 60;
                default: pct = 95;
            endcase
            for (int c = 0; c < 1400; c++) begin
                @(negedge clock);
                rst = ($urandom_range(0, 999) == 0);
                bus.rw_idle   = ($urandom_range(0, 99) < pct);
                bus.bank_open = $urandom_range(0, 1) == 1;
            end
            rst = 1'b0;
        end

        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/refresh_ctrl.md
REFRESH_CTRL -- requirements
Module: refresh_ctrl

Interface
REQ-001 SHALL have parameter tREFI, default 6240, meaning refresh interval in clock cycles.
REQ-002 SHALL have parameter tRFC, default 280, meaning REF-to-next-command cycles.
REQ-003 SHALL have parameter tRP, default 15, meaning PREA-to-REF cycles.
REQ-004 SHALL have parameter ALMOST_WIN, default 64, meaning cycles before interval expiry at which refresh_almost rises.
REQ-005 SHALL have parameter MAX_DEBT, default 8, meaning postponed-refresh limit.
REQ-006 SHALL have port clock, input, 1, meaning the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-008 SHALL have port ini_done, input, 1, meaning DRAM initialisation complete.
REQ-009 SHALL have port rw_idle, input, 1, meaning no read/write in flight and command bus free.
REQ-010 SHALL have port bank_open, input, 1, meaning at least one bank active.
REQ-011 SHALL have port refresh_almost, output, 1, meaning refresh imminent or owed.
REQ-012 SHALL have port busy, output, 1, meaning refresh_ctrl owns the command bus; arbiter issues no new ACT/CAS.
REQ-013 SHALL have port prea_rdy, output, 1, meaning one-cycle PREA command strobe.
REQ-014 SHALL have port refresh_rdy, output, 1, meaning one-cycle REF command strobe.
REQ-015 SHALL have port refresh_done, output, 1, meaning one-cycle pulse at tRFC expiry.
REQ-016 SHALL have port ref_debt, output, 4, meaning outstanding refresh count.
REQ-017 SHALL have port ref_err, output, 1, meaning sticky debt-overflow flag.

Function
REQ-018 SHALL implement states WAIT_INI, RUN, DRAIN, PREA, WAIT_RP, REF, WAIT_RFC.
REQ-019 SHALL hold the interval counter at 0 in WAIT_INI; SHALL go WAIT_INI->RUN the cycle after ini_done=1.
REQ-020 SHALL free-run the interval counter 0..tREFI-1 in every state except WAIT_INI, wrapping to 0.
REQ-021 SHALL increment ref_debt on each wrap; simultaneous wrap and REF leaves ref_debt unchanged.
REQ-022 SHALL saturate ref_debt at MAX_DEBT; a wrap at MAX_DEBT without a simultaneous REF SHALL set ref_err until reset.
REQ-023 SHALL drive refresh_almost=1 when ref_debt>0 or counter>=tREFI-ALMOST_WIN.
REQ-024 SHALL go RUN->DRAIN when ref_debt>0 and rw_idle=1 (opportunistic), or when ref_debt==MAX_DEBT (urgent).
REQ-025 SHALL drive busy=1 in every state except WAIT_INI and RUN.
REQ-026 SHALL stay in DRAIN until rw_idle=1, then go to PREA if bank_open=1, else REF.
REQ-027 SHALL assert prea_rdy for exactly the one PREA cycle, then enter WAIT_RP for tRP cycles, then REF.
REQ-028 SHALL assert refresh_rdy for exactly the one REF cycle, decrementing ref_debt.
REQ-029 SHALL hold WAIT_RFC for tRFC cycles, pulse refresh_done on the last, then return to RUN.
REQ-030 SHALL keep prea_rdy, refresh_rdy and refresh_done mutually exclusive.
REQ-031 SHALL use one shared down-counter for tRP/tRFC, loaded on state entry; width clog2 of the larger.

Reset
REQ-032 SHALL on reset enter WAIT_INI, zero the interval counter, timing counter and ref_debt, clear ref_err, and drive every output 0 on the following cycle.
REQ-033 SHALL on reset mid-sequence (any state) abort without issuing further PREA/REF strobes.

Structure
REQ-034 SHALL place the state enum refresh_state_e and default timing constants in ddr_pkg.
REQ-035 SHALL be a single module; no sub-module is required.

Verification (tREFI=100, tRFC=20, tRP=5, ALMOST_WIN=10, MAX_DEBT=8)
REQ-036 ini_done at cycle 0, rw_idle=1, bank_open=0 -> refresh_almost at counter 90; REF strobe 2 cycles after wrap; refresh_done 20 cycles after REF.
REQ-037 Same with bank_open=1 -> PREA strobe, REF exactly 6 cycles later, debt returns to 0.
REQ-038 rw_idle=0 for 850 cycles -> debt climbs to 8, busy rises at debt 8, REF issued within 2 cycles of rw_idle=1, ref_err stays 0.
REQ-039 rw_idle=0 through 9 wraps -> debt stays 8, ref_err=1 and sticky.
REQ-040 Reset asserted in WAIT_RFC -> next cycle all outputs 0, state WAIT_INI, no refresh_done.
REQ-041 Wrap coinciding with REF cycle at debt 1 -> ref_debt remains 1.
